// File: rtl/ram2_pkg.sv
// Shared defaults, word type and bus-operation decode for the ram2 block.
package ram2_pkg;

  localparam int unsigned RAM2_DATA_W = 32;
  localparam int unsigned RAM2_ADDR_W = 5;
  localparam int unsigned RAM2_DEPTH  = 1 << RAM2_ADDR_W;

  typedef logic [RAM2_DATA_W-1:0] word_t;

  typedef enum logic [1:0] {
    OP_IDLE,
    OP_READ,
    OP_WRITE
  } bus_op_e;

  function automatic bus_op_e decode_op(input logic ena, input logic wena);
    if (!ena) return OP_IDLE;
    return wena ? OP_WRITE : OP_READ;
  endfunction

endpackage

// File: rtl/ram2_if.sv
// Internal link between the bus front end and the storage array.
interface ram2_if
  import ram2_pkg::*;
#(
  parameter int unsigned DATA_W = RAM2_DATA_W,
  parameter int unsigned ADDR_W = RAM2_ADDR_W
) ();

  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;

  modport master (output we, output addr, output wdata, input rdata);
  modport slave  (input we, input addr, input wdata, output rdata);

endinterface

// File: rtl/ram2_array.sv
// Word storage: synchronous write, synchronous clear, asynchronous read.
module ram2_array
  import ram2_pkg::*;
#(
  parameter int unsigned DATA_W = RAM2_DATA_W,
  parameter int unsigned ADDR_W = RAM2_ADDR_W,
  parameter int unsigned DEPTH  = RAM2_DEPTH
) (
  input  logic   clk,
  input  logic   rst,
  ram2_if.slave  mem_if
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic              in_range;

  // Addresses past DEPTH are ignored on write and read back as zero.
  always_comb begin
    in_range = (32'(mem_if.addr) < DEPTH);
    mem_d    = mem_q;
    if (mem_if.we && in_range) begin
      mem_d[mem_if.addr] = mem_if.wdata;
    end
    mem_if.rdata = in_range ? mem_q[mem_if.addr] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/ram2.sv
// Single-port RAM with a shared bidirectional data bus; top holds only bus control.
module ram2
  import ram2_pkg::*;
#(
  parameter int unsigned DATA_W = RAM2_DATA_W,
  parameter int unsigned ADDR_W = RAM2_ADDR_W,
  parameter int unsigned DEPTH  = RAM2_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              wena,
  input  logic [ADDR_W-1:0] addr,
  inout  wire  [DATA_W-1:0] data
);

  ram2_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) mem_if ();

  bus_op_e op;

  always_comb begin
    op           = decode_op(ena, wena);
    mem_if.we    = (op == OP_WRITE);
    mem_if.addr  = addr;
    mem_if.wdata = data;
  end

  // Drive the bus only for reads; otherwise release it to the external master.
  assign data = (op == OP_READ) ? mem_if.rdata : 'z;

  ram2_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk    (clk),
    .rst    (rst),
    .mem_if (mem_if)
  );

endmodule

// File: tb/tb_ram2.sv
// Scoreboard bench for ram2: directed scenarios plus random traffic against an array model.
module tb_ram2;
  import ram2_pkg::*;

  localparam int unsigned DW    = RAM2_DATA_W;
  localparam int unsigned AW    = RAM2_ADDR_W;
  localparam int unsigned DEPTH = RAM2_DEPTH;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ena = 1'b0;
  logic          wena = 1'b0;
  logic [AW-1:0] addr = '0;
  logic          drv_en = 1'b1;
  word_t         drv_val = '0;
  wire  [DW-1:0] data;

  assign data = drv_en ? drv_val : 'z;

  ram2 #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .ena  (ena),
    .wena (wena),
    .addr (addr),
    .data (data)
  );

  always #10 clk = ~clk;

  typedef struct {
    string name;
    word_t val;
  } exp_t;

  exp_t        sb_q[$];
  word_t       ref_mem [DEPTH];
  int unsigned total = 0;
  int unsigned bad   = 0;

  initial begin
    foreach (ref_mem[i]) ref_mem[i] = '0;
  end

  // Monitor: the bus is sampled mid-cycle, after inputs settle.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      total++;
      if (data !== e.val) begin
        bad++;
        $display("FAIL %s: data=%h expected=%h (t=%0t)", e.name, data, e.val, $time);
      end
    end
  end

  // One bus cycle. When the block is not reading, the bench owns the bus and
  // expects to see exactly its own value (any block drive would corrupt it).
  task automatic apply(input string name, input logic r, input logic e, input logic w,
                       input logic [AW-1:0] a, input word_t v,
                       input bit late = 1'b0, input word_t lv = '0, input bit chk = 1'b1);
    word_t wv;
    @(posedge clk);
    #1;
    rst  = r;
    ena  = e;
    wena = w;
    addr = a;
    if (e && !w) begin
      drv_en = 1'b0;
      if (chk) sb_q.push_back('{name, ref_mem[a]});
    end else begin
      drv_en  = 1'b1;
      drv_val = v;
      if (chk) sb_q.push_back('{name, v});
    end
    wv = late ? lv : v;
    if (r) begin
      foreach (ref_mem[i]) ref_mem[i] = '0;
    end else if (e && w) begin
      ref_mem[a] = wv;
    end
    if (late) begin
      #14;
      drv_val = lv;
    end
  endtask

  initial begin
    // Scenario 1: reset then read
    apply("s1_rst", 1'b1, 1'b0, 1'b0, 5'd5, '0, 1'b0, '0, 1'b0);
    apply("s1_rd5", 1'b0, 1'b1, 1'b0, 5'd5, '0);

    // Scenario 2: two writes, read back both
    apply("s2_wr0", 1'b0, 1'b1, 1'b1, 5'd0, 32'hF0FF0F0F);
    apply("s2_wr4", 1'b0, 1'b1, 1'b1, 5'd4, 32'hFF00FF00);
    apply("s2_rd4", 1'b0, 1'b1, 1'b0, 5'd4, '0);
    apply("s2_rd0", 1'b0, 1'b1, 1'b0, 5'd0, '0);

    // Scenario 3: data changes late in the write cycle; the edge value wins
    apply("s3_wr5", 1'b0, 1'b1, 1'b1, 5'd5, 32'h0, 1'b1, 32'hFFF0FFF0);
    apply("s3_rd5", 1'b0, 1'b1, 1'b0, 5'd5, '0);
    apply("s3_rd4", 1'b0, 1'b1, 1'b0, 5'd4, '0);

    // Scenario 4: disabled block neither drives nor writes
    apply("s4_off_rd4", 1'b0, 1'b0, 1'b0, 5'd4, 32'h0);
    apply("s4_off_wr6", 1'b0, 1'b0, 1'b1, 5'd6, 32'h12345678);
    apply("s4_rd6",     1'b0, 1'b1, 1'b0, 5'd6, '0);

    // Scenario 6: no block drive during writes
    apply("s6_wr_ff",   1'b0, 1'b1, 1'b1, 5'd9, 32'hFFFFFFFF);
    apply("s6_wr_zero", 1'b0, 1'b1, 1'b1, 5'd9, 32'h0);
    apply("s6_wr_ff2",  1'b0, 1'b1, 1'b1, 5'd9, 32'hFFFFFFFF);
    apply("s6_rd9",     1'b0, 1'b1, 1'b0, 5'd9, '0);

    // Scenario 5: reset beats a simultaneous write; read during reset sees old data
    apply("s5_rd_in_rst", 1'b1, 1'b1, 1'b0, 5'd4, '0);
    apply("s5_rst_wr3",   1'b1, 1'b1, 1'b1, 5'd3, 32'hAAAAAAAA);
    for (int i = 0; i < int'(DEPTH); i++) begin
      apply("s5_sweep", 1'b0, 1'b1, 1'b0, AW'(i), '0);
    end

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      int unsigned   sel;
      logic [AW-1:0] ra;
      word_t         rv;
      sel = $urandom_range(0, 99);
      ra  = AW'($urandom_range(0, DEPTH - 1));
      rv  = $urandom;
      if (sel < 2)       apply("rnd_rst", 1'b1, 1'($urandom), 1'b1, ra, rv);
      else if (sel < 55) apply("rnd_rd",  1'b0, 1'b1, 1'b0, ra, '0);
      else if (sel < 85) apply("rnd_wr",  1'b0, 1'b1, 1'b1, ra, rv);
      else               apply("rnd_off", 1'b0, 1'b0, 1'($urandom), ra, rv);
    end

    // Final sweep of all words
    for (int i = 0; i < int'(DEPTH); i++) begin
      apply("final_sweep", 1'b0, 1'b1, 1'b0, AW'(i), '0);
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: pending=%0d expected=0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram2.md
RAM2 -- requirements
Module: ram2

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the word width in bits.
REQ-002 Parameter ADDR_W, default 5, SHALL set the address width in bits.
REQ-003 Parameter DEPTH, default 32 (2**ADDR_W), SHALL set the number of words.
REQ-004 Port clk, input, 1 bit, SHALL be the single clock; all state changes occur on its rising edge.
REQ-005 Port rst, input, 1 bit, SHALL be a synchronous, active-high reset.
REQ-006 Port ena, input, 1 bit, SHALL be the chip enable; when low, the block neither reads nor writes.
REQ-007 Port wena, input, 1 bit, SHALL be the write enable; 1 selects write, 0 selects read.
REQ-008 Port addr, input, ADDR_W bits, SHALL be the word address.
REQ-009 Port data, inout, DATA_W bits, SHALL be the bidirectional data bus.

Function
REQ-010 Storage SHALL be DEPTH words of DATA_W bits, all zero at power-up or configuration.
REQ-011 Write: on a rising clk edge with rst=0, ena=1 and wena=1, mem[addr] SHALL take the value on data.
REQ-012 Read: while ena=1 and wena=0, the block SHALL drive data with mem[addr] combinationally (asynchronous read).
REQ-013 While ena=0 or wena=1, the block SHALL drive data to all-Z so that the external master can own the bus.
REQ-014 A change of addr during a read SHALL update data in the same delta, with no clock needed.
REQ-015 Read-after-write: after a write edge, a read of the same address SHALL return the new value immediately once wena falls.
REQ-016 When ena=0, a write SHALL NOT occur, whatever the value of wena.
REQ-017 Only the addressed word SHALL change on a write; all other words SHALL hold their values.
REQ-018 Every addr value from 0 to DEPTH-1 SHALL be valid; there is no wrap-around or out-of-range case at the defaults.
REQ-019 Data changes during a write cycle SHALL take effect only at the next rising edge; the value sampled is the one present at the edge.

Reset
REQ-020 On a rising clk edge with rst=1, every word SHALL be cleared to 0.
REQ-021 Reset SHALL take priority over a simultaneous write.
REQ-022 The bus drive state SHALL follow REQ-012 and REQ-013 during reset; a read during reset returns the old contents until the clearing edge, then 0.

Structure
REQ-023 A shared package ram2_pkg SHALL hold the DATA_W, ADDR_W and DEPTH defaults and the word typedef.
REQ-024 One sub-module, ram2_array, SHALL hold the storage with its synchronous write, reset clear and asynchronous read port.
REQ-025 The top level SHALL contain only the tristate bus control and the ena/wena decode.

Verification
REQ-026 Scenario 1: rst=1 for one edge, then ena=1, wena=0, addr=5 -> data=0x00000000.
REQ-027 Scenario 2: ena=1, wena=1, addr=0, data=0xF0FF0F0F for one edge; then addr=4, data=0xFF00FF00 for one edge; then wena=0 -> data=0xFF00FF00 at addr=4, and 0xF0FF0F0F at addr=0.
REQ-028 Scenario 3: write 0xFFF0FFF0 to addr=5, with data changed 5 ns before the edge; then read -> data=0xFFF0FFF0, and addr=4 is still 0xFF00FF00.
REQ-029 Scenario 4: ena=0 with any wena or addr -> data=Z from the block; then ena=0, wena=1, drive 0x12345678 at addr=6 -> a later read of addr=6 returns 0.
REQ-030 Scenario 5: rst=1 together with wena=1, addr=3, data=0xAAAAAAAA -> a later read of addr=3 returns 0, and all addresses 0 to 31 read 0.
REQ-031 Scenario 6: while ena=1 and wena=1, the block SHALL never drive the bus; check that there is no X on data while the bench drives 0xFFFFFFFF.
